// File: rtl/excess3_serial_adder.sv
// rtl/excess3_serial_adder.sv - digit-serial packed-BCD adder with packed excess-3 result
module excess3_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum_e3,
    output logic                carry_out,
    output logic                invalid
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [IW-1:0]  index;
    logic           carry;

    logic [3:0]     a_dig;
    logic [3:0]     b_dig;
    logic [4:0]     d_sum;
    logic [3:0]     r_dig;
    logic [3:0]     e3_dig;
    logic           next_carry;
    logic           last_digit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_RUN;
            S_RUN:   if (last_digit) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    // Digit select as a mux rather than a variable part-select keeps the
    // index in range for every DIGITS, including non-powers of two.
    always_comb begin
        a_dig = 4'd0;
        b_dig = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (index == IW'(k)) begin
                a_dig = a_q[4*k +: 4];
                b_dig = b_q[4*k +: 4];
            end
        end
        d_sum      = {1'b0, a_dig} + {1'b0, b_dig} + {4'd0, carry};
        next_carry = (d_sum > 5'd9);
        r_dig      = next_carry ? 4'(d_sum - 5'd10) : d_sum[3:0];
        e3_dig     = r_dig + 4'd3;
        last_digit = (index == IW'(DIGITS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            index     <= '0;
            carry     <= 1'b0;
            sum_e3    <= '0;
            carry_out <= 1'b0;
            invalid   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q       <= a;
                        b_q       <= b;
                        index     <= '0;
                        carry     <= 1'b0;
                        sum_e3    <= '0;
                        carry_out <= 1'b0;
                        invalid   <= 1'b0;
                    end
                end
                S_RUN: begin
                    for (int k = 0; k < DIGITS; k++) begin
                        if (index == IW'(k)) sum_e3[4*k +: 4] <= e3_dig;
                    end
                    carry   <= next_carry;
                    invalid <= invalid | (a_dig > 4'd9) | (b_dig > 4'd9);
                    if (last_digit) begin
                        carry_out <= next_carry;
                    end else begin
                        index <= index + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_excess3_serial_adder.sv
// tb/tb_excess3_serial_adder.sv - self-checking bench for excess3_serial_adder at DIGITS 1, 4 and 8
module tb_excess3_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_all = 1'b0;
    logic [63:0] a_all = '0;
    logic [63:0] b_all = '0;
    int          sel = 4;

    logic        start1, start4, start8;
    logic        busy1, busy4, busy8;
    logic        done1, done4, done8;
    logic [3:0]  sum1;
    logic [15:0] sum4;
    logic [31:0] sum8;
    logic        co1, co4, co8;
    logic        inv1, inv4, inv8;

    logic        cur_busy, cur_done, cur_co, cur_inv;
    logic [63:0] cur_sum;

    logic [63:0] last_sum;
    logic        last_co, last_inv;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    assign start1 = start_all && (sel == 1);
    assign start4 = start_all && (sel == 4);
    assign start8 = start_all && (sel == 8);

    excess3_serial_adder #(.DIGITS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a_all[3:0]), .b(b_all[3:0]),
        .busy(busy1), .done(done1), .sum_e3(sum1), .carry_out(co1), .invalid(inv1)
    );
    excess3_serial_adder #(.DIGITS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a_all[15:0]), .b(b_all[15:0]),
        .busy(busy4), .done(done4), .sum_e3(sum4), .carry_out(co4), .invalid(inv4)
    );
    excess3_serial_adder #(.DIGITS(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a_all[31:0]), .b(b_all[31:0]),
        .busy(busy8), .done(done8), .sum_e3(sum8), .carry_out(co8), .invalid(inv8)
    );

    always_comb begin
        cur_busy = busy4; cur_done = done4; cur_co = co4; cur_inv = inv4;
        cur_sum  = {48'd0, sum4};
        if (sel == 1) begin
            cur_busy = busy1; cur_done = done1; cur_co = co1; cur_inv = inv1;
            cur_sum  = {60'd0, sum1};
        end else if (sel == 8) begin
            cur_busy = busy8; cur_done = done8; cur_co = co8; cur_inv = inv8;
            cur_sum  = {32'd0, sum8};
        end
    end

    // Valid operands use plain decimal addition; operands with a digit >9
    // fall back to the digit-by-digit rule, which is all that defines them.
    function automatic void model(input int n, input logic [63:0] av, input logic [63:0] bv,
                                  output logic [63:0] s, output logic co, output logic inv);
        longint da = 0, db = 0, p = 1, tot;
        int ai, bi, d, r, c;
        inv = 1'b0;
        s   = '0;
        for (int i = 0; i < n; i++) begin
            ai = int'(av[4*i +: 4]);
            bi = int'(bv[4*i +: 4]);
            if (ai > 9 || bi > 9) inv = 1'b1;
            da += longint'(ai) * p;
            db += longint'(bi) * p;
            p  *= 10;
        end
        if (!inv) begin
            tot = da + db;
            co  = (tot >= p);
            tot = tot % p;
            for (int i = 0; i < n; i++) begin
                s[4*i +: 4] = 4'((tot % 10) + 3);
                tot = tot / 10;
            end
        end else begin
            c = 0;
            for (int i = 0; i < n; i++) begin
                d = int'(av[4*i +: 4]) + int'(bv[4*i +: 4]) + c;
                c = (d > 9) ? 1 : 0;
                r = ((d > 9) ? d - 10 : d) % 16;
                s[4*i +: 4] = 4'((r + 3) % 16);
            end
            co = c[0];
        end
    endfunction

    function automatic logic [63:0] gen(input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 11) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
            else                            v[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic op(input int n, input logic [63:0] av, input logic [63:0] bv, input string tag);
        logic [63:0] es;
        logic        ec, ei;
        int          cyc, nb;
        model(n, av, bv, es, ec, ei);
        sel = n;
        @(negedge clk);
        a_all = av; b_all = bv; start_all = 1'b1;
        @(negedge clk);
        start_all = 1'b0;
        a_all = {$urandom(), $urandom()};
        b_all = {$urandom(), $urandom()};
        cyc = 0; nb = 0;
        while (cur_done !== 1'b1 && cyc < 40) begin
            if (cur_busy === 1'b1) nb++;
            cyc++;
            @(negedge clk);
        end
        chk({tag, ":done"}, 64'(cur_done), 64'd1);
        chk({tag, ":busy_cycles"}, 64'(nb), 64'(n));
        chk({tag, ":busy_low"}, 64'(cur_busy), 64'd0);
        chk({tag, ":sum"}, cur_sum, es);
        chk({tag, ":carry"}, 64'(cur_co), 64'(ec));
        chk({tag, ":invalid"}, 64'(cur_inv), 64'(ei));
        last_sum = cur_sum; last_co = cur_co; last_inv = cur_inv;
        @(negedge clk);
        chk({tag, ":done_pulse"}, 64'(cur_done), 64'd0);
        chk({tag, ":hold_sum"}, cur_sum, es);
    endtask

    initial begin
        int          cyc, hits;
        int          dq[$];
        logic [63:0] ra, rb;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            sel = (k == 0) ? 1 : (k == 1) ? 4 : 8;
            #1;
            chk("rst:busy", 64'(cur_busy), 64'd0);
            chk("rst:done", 64'(cur_done), 64'd0);
            chk("rst:sum", cur_sum, 64'd0);
            chk("rst:carry_inv", {62'd0, cur_co, cur_inv}, 64'd0);
        end
        rst = 1'b0;

        op(4, 64'h1234, 64'h4321, "d4_basic");
        chk("d4_basic:const", {last_sum[15:0], 6'd0, last_co, last_inv}, {16'h8888, 8'h00});
        op(4, 64'h9999, 64'h0001, "d4_ovf");
        chk("d4_ovf:const", {last_sum[15:0], 6'd0, last_co, last_inv}, {16'h3333, 8'h02});
        op(4, 64'h0000, 64'h0000, "d4_zero");
        chk("d4_zero:const", {last_sum[15:0], 7'd0, last_co}, {16'h3333, 8'h00});
        op(4, 64'h0999, 64'h0001, "d4_ripple");
        chk("d4_ripple:const", {last_sum[15:0], 7'd0, last_co}, {16'h4333, 8'h00});
        op(4, 64'h00A0, 64'h0000, "d4_invalid");
        chk("d4_invalid:const", {last_sum[15:0], 6'd0, last_co, last_inv}, {16'h3433, 8'h01});
        op(4, 64'h1234, 64'h4321, "d4_clear_inv");
        chk("d4_clear_inv:const", 64'(last_inv), 64'd0);

        // start re-asserted with new operands through RUN and DONE
        sel = 4;
        @(negedge clk);
        a_all = 64'h1234; b_all = 64'h4321; start_all = 1'b1;
        @(negedge clk);
        a_all = 64'h9999; b_all = 64'h9999;
        cyc = 0;
        while (done4 !== 1'b1 && cyc < 20) begin cyc++; @(negedge clk); end
        chk("hs:done", 64'(done4), 64'd1);
        chk("hs:sum", 64'(sum4), 64'h8888);
        @(negedge clk);
        start_all = 1'b0;
        chk("hs:ignored_in_done", {62'd0, busy4, done4}, 64'd0);

        // start held high: one acceptance every DIGITS+2 cycles
        @(negedge clk);
        a_all = 64'h1234; b_all = 64'h4321; start_all = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done4 === 1'b1) begin
                dq.push_back(c);
                chk("cad:sum", 64'(sum4), 64'h8888);
            end
        end
        start_all = 1'b0;
        chk("cad:count", 64'(dq.size() >= 4), 64'd1);
        for (int i = 1; i < dq.size(); i++) chk("cad:gap", 64'(dq[i] - dq[i-1]), 64'd6);
        cyc = 0;
        while ((busy4 === 1'b1 || done4 === 1'b1) && cyc < 12) begin cyc++; @(negedge clk); end
        chk("cad:drain", {62'd0, busy4, done4}, 64'd0);

        // reset mid-RUN after edge 2
        @(negedge clk);
        a_all = 64'h12AA; b_all = 64'h3456; start_all = 1'b1;
        @(negedge clk);
        start_all = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mrst:pre_busy", 64'(busy4), 64'd1);
        chk("mrst:pre_inv", 64'(inv4), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst:busy", 64'(busy4), 64'd0);
        chk("mrst:sum", 64'(sum4), 64'd0);
        chk("mrst:carry_inv_done", {61'd0, co4, inv4, done4}, 64'd0);
        hits = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done4 === 1'b1 || busy4 === 1'b1) hits++;
        end
        chk("mrst:no_done", 64'(hits), 64'd0);
        op(4, 64'h1234, 64'h4321, "d4_after_rst");

        op(1, 64'h7, 64'h5, "d1_basic");
        chk("d1_basic:const", {last_sum[3:0], 7'd0, last_co}, {4'h5, 8'h01});
        op(8, 64'h00001234, 64'h00004321, "d8_basic");
        chk("d8_basic:const", {last_sum[31:0], 7'd0, last_co}, {32'h33338888, 8'h00});

        for (int t = 0; t < 12; t++) begin
            ra = gen(4); rb = gen(4);
            op(4, ra, rb, "rnd4");
        end
        for (int t = 0; t < 8; t++) begin
            ra = gen(8); rb = gen(8);
            op(8, ra, rb, "rnd8");
        end
        for (int t = 0; t < 8; t++) begin
            ra = gen(1); rb = gen(1);
            op(1, ra, rb, "rnd1");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
